// File: rtl/load_store_unit_if.sv
// Bundle of the core request/response handshake and the word-wide data
// memory port around the load/store unit. The unit itself uses the slave
// modport. The peer modport covers both the core pipeline and the memory
// instance that sit around the unit.
interface load_store_unit_if #(
  parameter int N = 32
);
  // core -> unit request channel
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;

  // unit -> core response channel
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_rdata;
  logic         resp_error;

  // unit <-> data memory (combinational read, write on posedge)
  logic [N-1:0] mem_address;
  logic [N-1:0] mem_data_write;
  logic         mem_write_enable;
  logic [N-1:0] mem_data_read;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    input  resp_ready,
    output mem_address, mem_data_write, mem_write_enable,
    input  mem_data_read
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    output resp_ready,
    input  mem_address, mem_data_write, mem_write_enable,
    output mem_data_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/halfword extraction on loads
// and read-modify-write on sub-word stores against a word-only memory.
//
//   state | meaning
//   IDLE  | ready for a request, memory port idle
//   READ  | word at mem_address is sampled at the next posedge
//   WRITE | mem_write_enable high for this single cycle
//   RESP  | response held until the core accepts it
module load_store_unit #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t       state_q, state_d;

  logic         write_q;
  logic [1:0]   size_q;
  logic         unsigned_q;
  logic [1:0]   off_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] mem_address_q;
  logic [N-1:0] mem_data_write_q;
  logic [N-1:0] resp_rdata_q;
  logic         resp_error_q;

  logic         accept;
  logic         req_err;
  logic         req_word_store;

  // Picks the addressed byte or halfword out of a little-endian word and
  // extends it to the full width.
  function automatic logic [N-1:0] load_extract(
    input logic [N-1:0] word,
    input logic [1:0]   size,
    input logic [1:0]   off,
    input logic         zext
  );
    logic [7:0]   b;
    logic [15:0]  h;
    logic [N-1:0] r;
    b = word[7:0];
    h = word[15:0];
    r = word;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (off[1]) begin
      h = word[31:16];
    end
    case (size)
      SIZE_BYTE: r = zext ? {{(N-8){1'b0}}, b}  : {{(N-8){b[7]}}, b};
      SIZE_HALF: r = zext ? {{(N-16){1'b0}}, h} : {{(N-16){h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replaces the addressed lane(s) of the old word with the store data.
  function automatic logic [N-1:0] store_merge(
    input logic [N-1:0] word,
    input logic [N-1:0] wdata,
    input logic [1:0]   size,
    input logic [1:0]   off
  );
    logic [N-1:0] m;
    m = word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    m[7:0]   = wdata[7:0];
          2'd1:    m[15:8]  = wdata[7:0];
          2'd2:    m[23:16] = wdata[7:0];
          default: m[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) begin
          m[31:16] = wdata[15:0];
        end else begin
          m[15:0] = wdata[15:0];
        end
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  // Request classification, evaluated on the live request inputs at accept.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = bus.req_addr[0];
      SIZE_WORD: req_err = (bus.req_addr[1:0] != 2'b00);
      default:   req_err = 1'b1;
    endcase
    req_word_store = bus.req_write && (bus.req_size == SIZE_WORD);
    accept         = (state_q == IDLE) && bus.req_valid;
  end

  // State register; reset drops any in-flight request or response at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/strobe decode; the write strobe is a pure state
  // decode so an async reset removes it before the memory's next edge.
  always_comb begin
    state_d              = state_q;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.mem_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err) begin
            state_d = RESP;
          end else if (req_word_store) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = write_q ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_write_enable = 1'b1;
        state_d              = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, memory word sampling and response data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q          <= 1'b0;
      size_q           <= 2'b00;
      unsigned_q       <= 1'b0;
      off_q            <= 2'b00;
      wdata_q          <= '0;
      mem_address_q    <= '0;
      mem_data_write_q <= '0;
      resp_rdata_q     <= '0;
      resp_error_q     <= 1'b0;
    end else begin
      if (accept) begin
        write_q       <= bus.req_write;
        size_q        <= bus.req_size;
        unsigned_q    <= bus.req_unsigned;
        off_q         <= bus.req_addr[1:0];
        wdata_q       <= bus.req_wdata;
        mem_address_q <= {bus.req_addr[N-1:2], 2'b00};
        resp_rdata_q  <= '0;
        resp_error_q  <= req_err;
        if (!req_err && req_word_store) begin
          mem_data_write_q <= bus.req_wdata;
        end
      end else if (state_q == READ) begin
        if (write_q) begin
          mem_data_write_q <= store_merge(bus.mem_data_read, wdata_q, size_q, off_q);
        end else begin
          resp_rdata_q <= load_extract(bus.mem_data_read, size_q, off_q, unsigned_q);
        end
      end
    end
  end

  assign bus.mem_address    = mem_address_q;
  assign bus.mem_data_write = mem_data_write_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_error     = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word-array memory behind the unit, and a
// byte-level reference model of loads, stores, errors and latency.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.N(32)) bus ();

  load_store_unit #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        fill_en = 1'b0;
  logic        pre_en  = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] pattern(input int i);
    return 32'(i) * 32'h9E37_79B1;
  endfunction

  assign bus.mem_data_read = mem[bus.mem_address[11:2]];

  // Memory model: bench fill/preload, else the unit's write strobe.
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pattern(i);
    end else if (pre_en) begin
      mem[pre_idx] <= pre_data;
    end else if (bus.mem_write_enable) begin
      mem[bus.mem_address[11:2]] <= bus.mem_data_write;
    end
  end

  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    if (size == 2'b11) return 1'b1;
    nb = 1 << size;
    return (addr % nb) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input int off, input bit uns);
    int nb;
    logic [63:0] v, mask;
    nb   = 1 << size;
    v    = {32'b0, word} >> (8 * off);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic [1:0] size, input int off);
    int nb;
    logic [63:0] mask, v;
    nb   = 1 << size;
    mask = ((64'd1 << (8 * nb)) - 64'd1) << (8 * off);
    v    = ({32'b0, word} & ~mask) | (({32'b0, wdata} << (8 * off)) & mask);
    return v[31:0];
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_idx  = addr[11:2];
    pre_data = data;
    pre_en   = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[addr[11:2]] = data;
  endtask

  // One complete transaction with its own latency/strobe/data checks.
  task automatic do_txn(input bit wr, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input string tag);
    bit          err;
    int          idx, off, exp_lat, exp_pulses, lat, pulses, n;
    logic [31:0] exp_rdata, exp_word, wa, wd, held_rdata;
    logic        held_err;
    err        = ref_err(size, addr);
    idx        = int'(addr[11:2]);
    off        = int'(addr[1:0]);
    exp_rdata  = (!err && !wr) ? ref_load(ref_mem[idx], size, off, uns) : 32'h0;
    exp_word   = (!err && wr) ? ref_store(ref_mem[idx], wdata, size, off) : ref_mem[idx];
    exp_pulses = (!err && wr) ? 1 : 0;
    exp_lat    = err ? 1 : (wr && size != 2'b10) ? 3 : 2;
    wa = '0; wd = '0;

    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL %s req_ready_wait got=%b want=1", tag, bus.req_ready);
    end

    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    // junk on the request channel while busy must be ignored
    bus.req_valid = 1'b1; bus.req_write = 1'($urandom);
    bus.req_size = 2'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;

    lat = 1; pulses = 0;
    while (bus.resp_valid !== 1'b1 && lat < 10) begin
      if (bus.mem_write_enable === 1'b1) begin
        pulses++; wa = bus.mem_address; wd = bus.mem_data_write;
      end
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != exp_lat || bus.resp_valid !== 1'b1) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, exp_lat);
    end
    total++;
    if (pulses != exp_pulses) begin
      bad++; $display("FAIL %s we_pulses got=%0d want=%0d", tag, pulses, exp_pulses);
    end
    if (exp_pulses == 1) begin
      total++;
      if (wa !== {addr[31:2], 2'b00} || wd !== exp_word) begin
        bad++; $display("FAIL %s write got=%h/%h want=%h/%h", tag, wa, wd,
                        {addr[31:2], 2'b00}, exp_word);
      end
    end
    total++;
    if (bus.resp_error !== err) begin
      bad++; $display("FAIL %s resp_error got=%b want=%b", tag, bus.resp_error, err);
    end
    total++;
    if (bus.resp_rdata !== exp_rdata) begin
      bad++; $display("FAIL %s resp_rdata got=%h want=%h", tag, bus.resp_rdata, exp_rdata);
    end
    total++;
    if (bus.req_ready !== 1'b0 || bus.mem_write_enable !== 1'b0) begin
      bad++; $display("FAIL %s resp_state got=%b%b want=00", tag, bus.req_ready,
                      bus.mem_write_enable);
    end

    held_rdata = bus.resp_rdata; held_err = bus.resp_error;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      total++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
          bus.resp_rdata !== held_rdata || bus.resp_error !== held_err) begin
        bad++; $display("FAIL %s hold%0d got v=%b r=%b d=%h want v=1 r=0 d=%h", tag, h,
                        bus.resp_valid, bus.req_ready, bus.resp_rdata, held_rdata);
      end
    end

    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL %s release got ready=%b valid=%b want 1/0", tag,
                      bus.req_ready, bus.resp_valid);
    end
    total++;
    if (mem[idx] !== exp_word) begin
      bad++; $display("FAIL %s mem_word got=%h want=%h", tag, mem[idx], exp_word);
    end
    ref_mem[idx] = exp_word;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_error !== 1'b0 || bus.mem_address !== 32'h0 ||
        bus.mem_data_write !== 32'h0 || bus.mem_write_enable !== 1'b0) begin
      bad++; $display("FAIL reset_values got rdy=%b v=%b d=%h e=%b a=%h w=%h we=%b",
                      bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error,
                      bus.mem_address, bus.mem_data_write, bus.mem_write_enable);
    end
    fill_en = 1'b1;
    @(posedge clk); #1;
    fill_en = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    preload(32'h100, 32'h8899_AABB);
    do_txn(0, 2'b00, 0, 32'h101, 32'h0, 0, "ld_b_101_s");
    do_txn(0, 2'b01, 1, 32'h102, 32'h0, 0, "ld_h_102_u");
    do_txn(0, 2'b01, 0, 32'h102, 32'h0, 0, "ld_h_102_s");
    do_txn(0, 2'b10, 0, 32'h100, 32'h0, 0, "ld_w_100");
    do_txn(0, 2'b00, 1, 32'h103, 32'h0, 0, "ld_b_103_u");
  endtask

  task automatic test_stores();
    preload(32'h200, 32'h1122_3344);
    do_txn(1, 2'b00, 0, 32'h202, 32'h1234_56EE, 0, "st_b_202");
    do_txn(1, 2'b01, 0, 32'h200, 32'hABCD_9876, 0, "st_h_200");
    do_txn(1, 2'b10, 0, 32'h204, 32'hCAFE_F00D, 0, "st_w_204");
  endtask

  task automatic test_errors();
    do_txn(0, 2'b01, 0, 32'h103, 32'h0, 0, "err_ld_h_103");
    do_txn(0, 2'b10, 0, 32'h102, 32'h0, 0, "err_ld_w_102");
    do_txn(0, 2'b11, 0, 32'h100, 32'h0, 0, "err_size3_ld");
    do_txn(1, 2'b11, 0, 32'h100, 32'h5555_5555, 0, "err_size3_st");
    do_txn(1, 2'b01, 0, 32'h201, 32'h7777_7777, 0, "err_st_h_201");
  endtask

  task automatic test_back_to_back();
    do_txn(0, 2'b10, 0, 32'h100, 32'h0, 5, "hold5_ld");
    do_txn(0, 2'b00, 0, 32'h100, 32'h0, 0, "b2b_ld");
    do_txn(1, 2'b00, 0, 32'h101, 32'h0000_0042, 2, "hold2_st");
  endtask

  task automatic test_reset_write();
    preload(32'h300, 32'h0102_0304);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h300; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++;
    if (bus.mem_write_enable !== 1'b1) begin
      bad++; $display("FAIL rstwr_in_write got we=%b want=1", bus.mem_write_enable);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_write_enable !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_rdata !== 32'h0 || bus.resp_error !== 1'b0 ||
        bus.mem_address !== 32'h0 || bus.mem_data_write !== 32'h0) begin
      bad++; $display("FAIL rstwr_outputs got we=%b rdy=%b v=%b a=%h w=%h want reset values",
                      bus.mem_write_enable, bus.req_ready, bus.resp_valid,
                      bus.mem_address, bus.mem_data_write);
    end
    @(posedge clk); #1;
    total++;
    if (mem[32'h300 >> 2] !== 32'h0102_0304) begin
      bad++; $display("FAIL rstwr_mem got=%h want=01020304", mem[32'h300 >> 2]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn(0, 2'b10, 0, 32'h300, 32'h0, 0, "rstwr_reload");
  endtask

  task automatic test_random();
    logic [1:0]  size;
    logic [31:0] addr;
    for (int k = 0; k < 80; k++) begin
      size = 2'($urandom_range(0, 3));
      addr = {20'h0, 12'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'b01) addr[0] = 1'b0;
        if (size == 2'b10) addr[1:0] = 2'b00;
      end
      do_txn(1'($urandom), size, 1'($urandom), addr, $urandom,
             int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
